strip_frame_buffer: RTL and testbench
=====================================

Name: strip_frame_buffer

Overview:
Double-buffered (ping-pong) pixel byte store sitting directly upstream of the strip driver. The upstream byte stream (SPI/UART receiver) fills the back buffer through a valid/ready port. The strip driver reads the front buffer through its mem_addr/mem_data port. Buffers swap only while the strip driver signals a safe point (reset band), so a refresh never mixes two frames.

Parameters:
ADDRESS_WIDTH, 13, width of rd_addr; matches the strip driver mem_addr width.
FRAME_BYTES, 9, bytes per frame (LEDs x channels); each buffer holds this many bytes.
BASE_ADDRESS, 0, address of byte 0 of the frame on the read port.

Ports:
clk  in  1  single clock for all logic
rst  in  1  reset; asynchronous, active-low
in_data  in  8  byte from upstream stream
in_valid  in  1  in_data is valid this cycle
in_sof  in  1  qualified by in_valid; marks first byte of a frame
in_ready  out  1  block accepts in_data this cycle
rd_addr  in  ADDRESS_WIDTH  read address from strip driver (mem_addr)
rd_data  out  8  front-buffer byte (mem_data)
swap_ok  in  1  high while strip driver is in its reset band
frame_swapped  out  1  one-cycle pulse when buffers swap
front_sel  out  1  index of the buffer currently being displayed
sof_errors  out  8  saturating count of frames restarted mid-fill

Behaviour:
- Reset (rst low, async assert; synchronous deassert is the integrator's job):
  - in_ready=0, rd_data=0, frame_swapped=0, front_sel=0, sof_errors=0.
  - Write pointer wr_ptr=0; state=LOAD.
  - Both buffers read as 0 after reset: contents are cleared by a per-buffer valid flag, not by RAM init.
- Storage:
  - Two arrays of FRAME_BYTES x 8, or one 2*FRAME_BYTES RAM indexed by {buffer, offset}.
  - Back buffer = !front_sel.
- Write port:
  - A transfer occurs when in_valid && in_ready.
  - LOAD state: in_ready=1.
  - Accepted byte with in_sof=1: written at offset 0; wr_ptr<=1.
    - If wr_ptr was nonzero, a partial frame is discarded and sof_errors increments, saturating at 255.
  - Accepted byte with in_sof=0: written at offset wr_ptr; wr_ptr<=wr_ptr+1.
  - Byte with in_sof=0 while wr_ptr==0: written at offset 0. No SOF is required for the first frame after reset.
  - When the byte at offset FRAME_BYTES-1 is accepted: state<=PENDING; in_ready=0 from the next cycle; the back buffer's valid flag is set.
- PENDING state:
  - in_ready=0; no writes.
  - On any cycle with swap_ok=1: front_sel<=!front_sel; frame_swapped=1 for exactly one cycle; wr_ptr<=0; state<=LOAD.
  - in_ready=1 on the cycle after the swap.
- swap_ok high in LOAD has no effect. A swap never happens without a complete frame.
- Read port:
  - rd_data is registered with 1-cycle latency: rd_data(t+1) = front[rd_addr(t) - BASE_ADDRESS].
  - Out-of-range addresses return 0: rd_addr < BASE_ADDRESS, or rd_addr - BASE_ADDRESS >= FRAME_BYTES. Compute the subtraction at ADDRESS_WIDTH+1 bits to catch underflow.
  - A front buffer whose valid flag is clear returns 0.
  - A read on the swap cycle uses the old front_sel. The next cycle uses the new one.
- Simultaneous events:
  - Final byte accepted while swap_ok=1: no swap that cycle. The swap occurs on the first PENDING cycle with swap_ok=1, at the earliest the next cycle.
  - Reads and writes never touch the same buffer, so there are no collisions.
- Reset mid-operation: all state returns to reset values immediately. A partially written frame is lost and both valid flags clear.
- No combinational path from in_valid to in_ready.

Test Plan:
1. Reset, then read addr 0..8 -> rd_data=0 for every address, 1 cycle after each address.
2. Send 9 bytes 0x11..0x99 (SOF on first), swap_ok=0 -> in_ready drops after the 9th byte, front_sel stays 0. Then pulse swap_ok -> frame_swapped one cycle, front_sel=1, read addr 0..8 returns 0x11..0x99, in_ready=1 the cycle after.
3. Send 4 bytes, then SOF+9 bytes 0xA0..0xA8, swap -> sof_errors=1, front holds 0xA0..0xA8.
4. BASE_ADDRESS=4: read addr 3 and addr 13 -> 0. Read addr 4 -> first frame byte.
5. Fill frame B while frame A is displayed, with reads at all 9 addresses interleaved every cycle -> reads return only A bytes until frame_swapped, then only B bytes.
6. Assert rst low mid-fill at wr_ptr=5 -> outputs return to reset values asynchronously. Then a fresh 9-byte frame and swap display correctly.

Source files
------------

// File: rtl/strip_frame_buffer_if.sv
// Upstream byte-stream port of the strip frame buffer.
//   in_data  : byte from the upstream receiver
//   in_valid : in_data is valid this cycle
//   in_sof   : qualified by in_valid; first byte of a frame
//   in_ready : buffer accepts in_data this cycle
// master = upstream byte source, slave = strip_frame_buffer.
interface strip_frame_buffer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_sof, input in_ready);
    modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/strip_frame_buffer.sv
// Ping-pong pixel byte store feeding the strip driver.
// The upstream stream fills the back buffer; the strip driver reads the front buffer.
// Buffers swap only while swap_ok (driver reset band) is high, so a refresh never
// mixes two frames.
// Ports:
//   clk, rst      : clock; asynchronous active-low reset
//   up            : upstream byte stream (in_data/in_valid/in_sof/in_ready)
//   rd_addr       : strip driver read address (mem_addr)
//   rd_data       : front-buffer byte, registered, 1-cycle latency (mem_data)
//   swap_ok       : high while the strip driver is in its reset band
//   frame_swapped : one-cycle pulse, coincident with the new front_sel
//   front_sel     : index of the buffer being displayed
//   sof_errors    : saturating count of frames restarted mid-fill
module strip_frame_buffer #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned FRAME_BYTES   = 9,
    parameter int unsigned BASE_ADDRESS  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    strip_frame_buffer_if.slave      up,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [7:0]               rd_data,
    input  logic                     swap_ok,
    output logic                     frame_swapped,
    output logic                     front_sel,
    output logic [7:0]               sof_errors
);
    localparam int unsigned PtrW     = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned AddrExtW = ADDRESS_WIDTH + 1;
    localparam logic [PtrW-1:0]     LastOff  = PtrW'(FRAME_BYTES - 1);
    localparam logic [AddrExtW-1:0] BaseExt  = AddrExtW'(BASE_ADDRESS);
    localparam logic [AddrExtW-1:0] FrameExt = AddrExtW'(FRAME_BYTES);

    typedef enum logic {StLoad, StPending} state_e;

    state_e          state_q, state_d;
    logic            ready_q;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic            front_q, front_d;
    logic            swapped_q, swapped_d;
    logic [7:0]      sof_err_q, sof_err_d;
    logic [1:0]      valid_q, valid_d;
    logic [7:0]      rd_data_q, rd_data_d;

    logic [7:0]      mem [2][FRAME_BYTES];

    logic            accept;
    logic [PtrW-1:0] wr_off;
    logic [AddrExtW-1:0] rel_addr;
    logic [PtrW-1:0] rd_off;

    // ready_q is high only in StLoad (it registers state_d), so accept implies StLoad.
    assign accept = up.in_valid && ready_q;
    assign wr_off = up.in_sof ? '0 : wr_ptr_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        front_d   = front_q;
        swapped_d = 1'b0;
        sof_err_d = sof_err_q;
        valid_d   = valid_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    wr_ptr_d = wr_off + 1'b1;
                    if (up.in_sof && (wr_ptr_q != '0) && (sof_err_q != 8'hff)) begin
                        sof_err_d = sof_err_q + 8'd1;
                    end
                    if (wr_off == LastOff) begin
                        state_d           = StPending;
                        valid_d[~front_q] = 1'b1;
                    end
                end
            end
            StPending: begin
                if (swap_ok) begin
                    front_d   = ~front_q;
                    swapped_d = 1'b1;
                    wr_ptr_d  = '0;
                    state_d   = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Subtract at one extra bit: an underflow sets the MSB and fails the range test.
    always_comb begin
        rel_addr  = {1'b0, rd_addr} - BaseExt;
        rd_off    = rel_addr[PtrW-1:0];
        rd_data_d = '0;
        if ((rel_addr < FrameExt) && valid_q[front_q]) begin
            rd_data_d = mem[front_q][rd_off];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StLoad;
            ready_q   <= 1'b0;
            wr_ptr_q  <= '0;
            front_q   <= 1'b0;
            swapped_q <= 1'b0;
            sof_err_q <= '0;
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == StLoad);
            wr_ptr_q  <= wr_ptr_d;
            front_q   <= front_d;
            swapped_q <= swapped_d;
            sof_err_q <= sof_err_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: the valid flags mask stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[~front_q][wr_off] <= up.in_data;
        end
    end

    assign up.in_ready    = ready_q;
    assign rd_data        = rd_data_q;
    assign frame_swapped  = swapped_q;
    assign front_sel      = front_q;
    assign sof_errors     = sof_err_q;
endmodule

// File: tb/tb_strip_frame_buffer.sv
// Self-checking bench for strip_frame_buffer.
// Two instances share one byte stream: dut_a (BASE_ADDRESS=0) and dut_b (BASE_ADDRESS=4).
module tb_strip_frame_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swap_ok = 1'b0;
    logic [12:0] rd_addr = '0;
    logic [12:0] rd_addr_b = '0;
    logic [7:0]  rd_data, rd_data_b;
    logic        frame_swapped, frame_swapped_b;
    logic        front_sel, front_sel_b;
    logic [7:0]  sof_errors, sof_errors_b;

    int n_cmp = 0;
    int n_err = 0;

    strip_frame_buffer_if ifa ();
    strip_frame_buffer_if ifb ();

    assign ifb.in_data  = ifa.in_data;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.in_sof   = ifa.in_sof;

    strip_frame_buffer #(.ADDRESS_WIDTH(13), .FRAME_BYTES(9), .BASE_ADDRESS(0)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .up            (ifa.slave),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .swap_ok       (swap_ok),
        .frame_swapped (frame_swapped),
        .front_sel     (front_sel),
        .sof_errors    (sof_errors)
    );

    strip_frame_buffer #(.ADDRESS_WIDTH(13), .FRAME_BYTES(9), .BASE_ADDRESS(4)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .up            (ifb.slave),
        .rd_addr       (rd_addr_b),
        .rd_data       (rd_data_b),
        .swap_ok       (swap_ok),
        .frame_swapped (frame_swapped_b),
        .front_sel     (front_sel_b),
        .sof_errors    (sof_errors_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        sof;
        logic        swap;
        logic [12:0] addr;
        logic        exp_ready;
        logic        exp_swapped;
        logic        exp_front;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic s,
                                input logic sw, input int a, input logic er,
                                input logic es, input logic ef, input logic [7:0] erd);
        vec_t r;
        r.data = d; r.valid = v; r.sof = s; r.swap = sw; r.addr = 13'(a);
        r.exp_ready = er; r.exp_swapped = es; r.exp_front = ef; r.exp_rd = erd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof);
        int k = 0;
        while (!ifa.in_ready && k < 20) begin
            tick();
            k++;
        end
        check("send_ready", 32'(ifa.in_ready), 32'd1);
        ifa.in_data  = d;
        ifa.in_sof   = sof;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_a [9];
        logic [7:0] exp_b [9];
        int         b_addr [4];
        logic [7:0] b_exp [4];

        ifa.in_data  = '0;
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;

        // Reset values, checked asynchronously before any clock edge
        #1 rst = 1'b0;
        #1;
        check("rst_ready", 32'(ifa.in_ready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_swapped", 32'(frame_swapped), 32'd0);
        check("rst_front", 32'(front_sel), 32'd0);
        check("rst_sof_err", 32'(sof_errors), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        check("rel_ready", 32'(ifa.in_ready), 32'd0);

        // Test 1: reads after reset return 0, plus one out-of-range address
        for (int k = 0; k <= 9; k++) tbl.push_back(mk(8'h00, 0, 0, 0, k, 1, 0, 0, 8'h00));
        // Test 2: first frame 0x11..0x99, ready drops after byte 9
        for (int j = 0; j < 9; j++) begin
            tbl.push_back(mk(8'(8'h11 * (j + 1)), 1, (j == 0), 0, 0, (j != 8), 0, 0, 8'h00));
        end
        tbl.push_back(mk(8'hEE, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        // Swap cycle: read uses old (invalid) front
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1, 1, 1, 8'h00));
        for (int k = 0; k < 9; k++) begin
            tbl.push_back(mk(8'h00, 0, 0, 0, k, 1, 0, 1, 8'(8'h11 * (k + 1))));
        end
        tbl.push_back(mk(8'h00, 0, 0, 0, 9, 1, 0, 1, 8'h00));

        foreach (tbl[i]) begin
            ifa.in_data  = tbl[i].data;
            ifa.in_valid = tbl[i].valid;
            ifa.in_sof   = tbl[i].sof;
            swap_ok      = tbl[i].swap;
            rd_addr      = tbl[i].addr;
            tick();
            check($sformatf("tbl%0d_ready", i), 32'(ifa.in_ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_swapped", i), 32'(frame_swapped), 32'(tbl[i].exp_swapped));
            check($sformatf("tbl%0d_front", i), 32'(front_sel), 32'(tbl[i].exp_front));
            check($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
        end
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        swap_ok      = 1'b0;

        // Test 4: BASE_ADDRESS=4 instance holds the same frame
        check("b_front", 32'(front_sel_b), 32'd1);
        b_addr[0] = 3;  b_exp[0] = 8'h00;
        b_addr[1] = 13; b_exp[1] = 8'h00;
        b_addr[2] = 4;  b_exp[2] = 8'h11;
        b_addr[3] = 12; b_exp[3] = 8'h99;
        for (int k = 0; k < 4; k++) begin
            rd_addr_b = 13'(b_addr[k]);
            tick();
            check($sformatf("b_rd_addr%0d", b_addr[k]), 32'(rd_data_b), 32'(b_exp[k]));
        end

        // Test 3: partial frame, swap_ok in LOAD ignored, SOF restart, final byte with swap_ok
        for (int k = 0; k < 4; k++) send_byte(8'(k + 1), (k == 0));
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        check("load_swap_ignored", 32'(frame_swapped), 32'd0);
        check("load_front_kept", 32'(front_sel), 32'd1);
        send_byte(8'hA0, 1'b1);
        check("sof_err_one", 32'(sof_errors), 32'd1);
        for (int k = 1; k < 8; k++) send_byte(8'(8'hA0 + k), 1'b0);
        swap_ok = 1'b1;
        send_byte(8'hA8, 1'b0);
        check("final_no_swap", 32'(frame_swapped), 32'd0);
        check("final_front_kept", 32'(front_sel), 32'd1);
        check("final_ready_low", 32'(ifa.in_ready), 32'd0);
        tick();
        swap_ok = 1'b0;
        check("late_swap_pulse", 32'(frame_swapped), 32'd1);
        check("late_swap_front", 32'(front_sel), 32'd0);
        check("late_swap_ready", 32'(ifa.in_ready), 32'd1);
        tick();
        check("pulse_one_cycle", 32'(frame_swapped), 32'd0);

        // Test 5: fill B while A displayed, reads every cycle
        for (int k = 0; k < 9; k++) begin
            exp_a[k] = 8'(8'hA0 + k);
            exp_b[k] = 8'(8'hB0 + k);
        end
        for (int c = 0; c <= 20; c++) begin
            ifa.in_valid = (c < 9);
            ifa.in_data  = 8'(8'hB0 + c);
            ifa.in_sof   = (c == 0);
            swap_ok      = (c == 11);
            rd_addr      = 13'(c % 9);
            tick();
            check($sformatf("il%0d_rd", c), 32'(rd_data),
                  32'((c <= 11) ? exp_a[c % 9] : exp_b[c % 9]));
            check($sformatf("il%0d_swapped", c), 32'(frame_swapped), 32'(c == 11));
            check($sformatf("il%0d_ready", c), 32'(ifa.in_ready), 32'((c < 8) || (c >= 11)));
            check($sformatf("il%0d_front", c), 32'(front_sel), 32'(c >= 11));
        end
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        swap_ok      = 1'b0;

        // Test 6: reset mid-fill at wr_ptr=5
        for (int k = 0; k < 5; k++) send_byte(8'(8'hC0 + k), (k == 0));
        #3 rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ifa.in_ready), 32'd0);
        check("mid_rst_rd", 32'(rd_data), 32'd0);
        check("mid_rst_front", 32'(front_sel), 32'd0);
        check("mid_rst_swapped", 32'(frame_swapped), 32'd0);
        check("mid_rst_sof_err", 32'(sof_errors), 32'd0);
        tick();
        rst = 1'b1;
        rd_addr = 13'd0;
        tick();
        check("post_rst_rd_invalid", 32'(rd_data), 32'd0);

        // sof_errors saturates at 255
        ifa.in_data  = 8'h55;
        ifa.in_sof   = 1'b1;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
        check("sof_err_sat", 32'(sof_errors), 32'd255);
        rst = 1'b0;
        #1;
        check("sat_rst_sof_err", 32'(sof_errors), 32'd0);
        tick();
        rst = 1'b1;

        // Fresh frame with no SOF after reset, then swap and read back
        for (int k = 0; k < 9; k++) send_byte(8'(8'hC1 + k), 1'b0);
        check("fresh_ready_low", 32'(ifa.in_ready), 32'd0);
        check("fresh_sof_err", 32'(sof_errors), 32'd0);
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        check("fresh_swapped", 32'(frame_swapped), 32'd1);
        check("fresh_front", 32'(front_sel), 32'd1);
        for (int k = 0; k < 9; k++) begin
            rd_addr = 13'(k);
            tick();
            check($sformatf("fresh_rd%0d", k), 32'(rd_data), 32'(8'(8'hC1 + k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
